e_mdu: RTL and testbench

Execute-stage multiply/divide unit. It consumes the operands and decoded op carried by the D→E pipeline register: rs_d, rt_d and the E-stage instruction.
- It computes MULT/MULTU/DIV/DIVU into the architectural HI/LO registers over a fixed multi-cycle latency.
- It also handles MTHI/MTLO writes.
- It exposes busy so the hazard unit can stall the next mult/div/mfhi/mflo in D.

---
 rtl/e_mdu_pkg.sv | 43 ++++
 rtl/e_mdu.sv | 128 ++++++++++++
 tb/tb_e_mdu.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared constants for the execute-stage multiply/divide unit.
// The E-stage decoder uses the same md_op encodings.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Returns {remainder, quotient}. Signed mode divides magnitudes and then
  // restores signs, which also yields 0x80000000 for 0x80000000 / -1.
  function automatic logic [63:0] div_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    ua = (is_signed && a[31]) ? -a : a;
    ub = (is_signed && b[31]) ? -b : b;
    if (ub == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (is_signed && (a[31] ^ b[31])) q = -q;
    if (is_signed && a[31]) r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency MULT/DIV into HI/LO,
// single-cycle MTHI/MTLO, and a registered busy for the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_skip_q, pend_skip_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_s;
  logic [63:0] div_u;

  // Sign-extending to 64 bits makes the low 64 bits of the product exact.
  assign prod_s = {{32{rs_d[31]}}, rs_d} * {{32{rt_d[31]}}, rt_d};
  assign prod_u = {32'd0, rs_d} * {32'd0, rt_d};
  assign div_s  = div_result(rs_d, rt_d, 1'b1);
  assign div_u  = div_result(rs_d, rt_d, 1'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_skip_q <= pend_skip_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_skip_d = pend_skip_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_skip_d = 1'b0;
              count_d     = MULT_N;
              state_d     = RUN;
            end
            MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_skip_d = 1'b0;
              count_d     = MULT_N;
              state_d     = RUN;
            end
            MD_DIV: begin
              {pend_hi_d, pend_lo_d} = div_s;
              pend_skip_d = (rt_d == 32'd0);
              count_d     = DIV_N;
              state_d     = RUN;
            end
            MD_DIVU: begin
              {pend_hi_d, pend_lo_d} = div_u;
              pend_skip_d = (rt_d == 32'd0);
              count_d     = DIV_N;
              state_d     = RUN;
            end
            MD_MTHI: hi_d = rs_d;
            MD_MTLO: lo_d = rs_d;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_d = count_q - ONE;
        // Divide-by-zero still occupies the unit but leaves HI/LO untouched.
        if (count_q == ONE) begin
          state_d = IDLE;
          if (!pend_skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    hi_out = hi_q;
    lo_out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_d   (rs_d),
    .rt_d   (rt_d),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op on HI/LO, from the ISA rules.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        q = sa * sb;
        ref_hi = q[63:32];
        ref_lo = q[31:0];
      end
      OP_MULTU: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        ref_hi = pu[63:32];
        ref_lo = pu[31:0];
      end
      OP_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        ref_lo = q[31:0];
        ref_hi = r[31:0];
      end
      OP_DIVU: if (b != 0) begin
        ref_lo = a / b;
        ref_hi = a % b;
      end
      OP_MTHI: ref_hi = a;
      OP_MTLO: ref_lo = a;
      default: ;
    endcase
  endtask

  function automatic int latency(input logic [2:0] op);
    if (op == OP_MULT || op == OP_MULTU) return MULT_N;
    if (op == OP_DIV || op == OP_DIVU) return DIV_N;
    return 0;
  endfunction

  // Entered and left at a falling edge; start is presented for one rising edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    rs_d  = a;
    rt_d  = b;
    @(negedge clk);
    start = 1'b0;
    rs_d  = $urandom;
    rt_d  = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = latency(op);
    apply_stimulus(op, a, b);
    for (int i = 0; i < n; i++) begin
      check_output({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (i == n - 1) begin
        check_output({tag, "_hi_early"}, hi_out, ref_hi);
        check_output({tag, "_lo_early"}, lo_out, ref_lo);
      end
      @(negedge clk);
    end
    model_op(op, a, b);
    check_output({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_hi"}, hi_out, ref_hi);
    check_output({tag, "_lo"}, lo_out, ref_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    reset  = 1'b0;
    start  = 1'b0;
    md_op  = OP_NONE;
    rs_d   = '0;
    rt_d   = '0;
    ref_hi = '0;
    ref_lo = '0;

    repeat (2) @(negedge clk);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_hi", hi_out, 32'd0);
    check_output("rst_lo", lo_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_output("post_rst_busy", {31'd0, busy}, 32'd0);
    check_output("post_rst_hi", hi_out, 32'd0);

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    check_output("mult_hi_const", hi_out, 32'hFFFF_FFFF);
    check_output("mult_lo_const", lo_out, 32'hFFFF_FFFA);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    check_output("multu_hi_const", hi_out, 32'h0000_0002);
    check_output("multu_lo_const", lo_out, 32'hFFFF_FFFA);

    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_output("div_lo_const", lo_out, 32'hFFFF_FFFD);
    check_output("div_hi_const", hi_out, 32'hFFFF_FFFF);
    run_op("divu", OP_DIVU, 32'd7, 32'd2);
    check_output("divu_lo_const", lo_out, 32'd3);
    check_output("divu_hi_const", hi_out, 32'd1);

    apply_stimulus(OP_MTHI, 32'h11, 32'd0);
    model_op(OP_MTHI, 32'h11, 32'd0);
    apply_stimulus(OP_MTLO, 32'h22, 32'd0);
    model_op(OP_MTLO, 32'h22, 32'd0);
    run_op("div0", OP_DIV, 32'd1234, 32'd0);
    check_output("div0_hi_const", hi_out, 32'h11);
    check_output("div0_lo_const", lo_out, 32'h22);
    run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("divovf_lo_const", lo_out, 32'h8000_0000);
    check_output("divovf_hi_const", hi_out, 32'h0);

    // MTHI then MTLO on consecutive rising edges.
    start = 1'b1;
    md_op = OP_MTHI;
    rs_d  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("mthi_hi", hi_out, 32'hDEAD_BEEF);
    check_output("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = OP_MTLO;
    rs_d  = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check_output("mtlo_lo", lo_out, 32'h1234_5678);
    check_output("mtlo_hi_kept", hi_out, 32'hDEAD_BEEF);
    check_output("mtlo_busy", {31'd0, busy}, 32'd0);
    ref_hi = 32'hDEAD_BEEF;
    ref_lo = 32'h1234_5678;

    // A DIV held on start during a MULT must be ignored; operands churn.
    a = 32'h0001_2345;
    b = 32'hFFFF_F000;
    start = 1'b1;
    md_op = OP_MULT;
    rs_d  = a;
    rt_d  = b;
    @(negedge clk);
    for (int i = 0; i < MULT_N; i++) begin
      check_output("hold_busy", {31'd0, busy}, 32'd1);
      md_op = OP_DIV;
      rs_d  = $urandom;
      rt_d  = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    model_op(OP_MULT, a, b);
    check_output("hold_busy_done", {31'd0, busy}, 32'd0);
    check_output("hold_hi", hi_out, ref_hi);
    check_output("hold_lo", lo_out, ref_lo);
    @(negedge clk);
    check_output("hold_no_restart", {31'd0, busy}, 32'd0);

    // Randomized mix of ops, including undefined encodings and zero divisors.
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'h0000_00FF;
      if (latency(op) != 0) begin
        run_op("rand", op, a, b);
      end else begin
        apply_stimulus(op, a, b);
        model_op(op, a, b);
        check_output("rand_busy", {31'd0, busy}, 32'd0);
        check_output("rand_hi", hi_out, ref_hi);
        check_output("rand_lo", lo_out, ref_lo);
      end
    end

    // Asynchronous reset in the middle of a divide.
    apply_stimulus(OP_DIV, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    check_output("mid_div_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_output("async_rst_busy", {31'd0, busy}, 32'd0);
    check_output("async_rst_hi", hi_out, 32'd0);
    check_output("async_rst_lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    repeat (DIV_N) @(negedge clk);
    check_output("after_rst_hi", hi_out, 32'd0);
    check_output("after_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
